window_buffer: RTL and testbench
================================

Name: window_buffer

Overview:
- Upstream neighbour of the Sobel stage: turns a raster-order 8-bit grayscale pixel stream into 3x3 neighbourhoods.
- Drives the Sobel stage's comp_matrix and sobel_en inputs directly.
- Holds two image lines in shift-register line buffers plus a 3x3 window register.
- Emits one window per interior pixel. There is no border padding, so each frame yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.

Parameters:
IMG_WIDTH, 8, pixels per line (>=3); sets line-buffer depth and column counter wrap
IMG_HEIGHT, 8, lines per frame (>=3); sets row counter wrap
CNT_BITS, 8, width of col/row counters (2^CNT_BITS >= max(IMG_WIDTH, IMG_HEIGHT))

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
clear  in  1  synchronous frame abort/restart; wins over pixel_valid
pixel_valid  in  1  pixel_in is valid this cycle; accepted unconditionally (no backpressure)
pixel_in  in  8  grayscale pixel, raster order, row 0 col 0 first
comp_matrix  out  [2:0][2:0][7:0]  3x3 window: [row][col]; [2][2] = newest pixel, [0][0] = oldest (two rows up, two cols left)
sobel_en  out  1  window valid; one-cycle pulse per interior window
frame_done  out  1  one-cycle pulse, coincident with the last sobel_en of a frame
busy  out  1  high from first accepted pixel until frame_done

Behaviour:
- Reset (n_rst low, async):
  - comp_matrix, line buffers, col/row counters all 0.
  - sobel_en=0, frame_done=0, busy=0, state=IDLE.
- Accept event (pixel_valid=1 and clear=0):
  - Window shifts left: [r][0]<=[r][1], [r][1]<=[r][2] for r=0..2.
  - New right column: [2][2]<=pixel_in; [1][2]<=line1 tail (same col, previous row); [0][2]<=line0 tail (same col, two rows up).
  - line1 shifts in pixel_in; line0 shifts in line1 tail.
  - Column counter increments. At IMG_WIDTH-1 it wraps to 0 and the row counter increments. Row wraps at IMG_HEIGHT-1.
- sobel_en:
  - Registered; asserted the cycle after an accept whose (row,col) has row>=2 and col>=2.
  - Latency is 1 cycle pixel-to-window.
  - comp_matrix is valid while sobel_en=1 and holds unchanged between accepts.
- frame_done: registered; asserted the cycle after accepting (IMG_HEIGHT-1, IMG_WIDTH-1). Counters return to (0,0) at that point.
- State machine:
  - IDLE: busy=0. First accept -> FILL.
  - FILL: rows 0-1 loading line buffers; sobel_en never asserted. Accept at (1, IMG_WIDTH-1) -> ACTIVE.
  - ACTIVE: windows emitted. Accept at (IMG_HEIGHT-1, IMG_WIDTH-1) -> IDLE, with frame_done pulsed next cycle.
- Gaps: pixel_valid low freezes counters, window, line buffers and state. sobel_en/frame_done are 0 in any cycle not following an accept.
- Row wrap: cols 0-1 of each row (row>=2) produce no sobel_en. The window still shifts so that col 2 sees correct left columns. Windows never span rows.
- Back-to-back frames: an accept in the cycle frame_done is high starts the next frame at (0,0), state FILL. There are no dead cycles.
- clear:
  - Next state IDLE; counters to 0; sobel_en=0, frame_done=0 on the following cycle.
  - Line buffer and window contents are don't-care (overwritten before use).
  - A pixel presented with clear is dropped.
- Reset mid-frame: all state returns to reset values immediately. The next frame must start from (0,0).
- Width rules: pixels pass through unmodified (8-bit). No arithmetic other than the counters.

Test Plan:
- 4x4 frame (IMG_WIDTH=IMG_HEIGHT=4), pixel=16*row+col, pixel_valid held high -> exactly 4 sobel_en pulses, 1 cycle after pixels 0x22,0x23,0x32,0x33. The first window is [0][*]={00,01,02}, [1][*]={10,11,12}, [2][*]={20,21,22}. frame_done coincides with the 4th pulse.
- Same frame with pixel_valid toggled 1,0,0,1... -> identical window contents and count. sobel_en never asserts in idle-gap cycles; comp_matrix is stable across gaps.
- Row wrap: 4x4 frame, check the window after 0x32 -> [0][*]={10,11,12}, [1][*]={20,21,22}, [2][*]={30,31,32}. No pulse after 0x30 or 0x31.
- Two 4x4 frames back-to-back (second frame pixels +0x80) -> 8 pulses, 2 frame_done pulses. The 5th window is {80,81,82 / 90,91,92 / A0,A1,A2}.
- clear asserted after pixel 0x21, then a full fresh frame -> no sobel_en before the fresh frame's 0x22. The fresh frame yields exactly 4 correct windows.
- n_rst pulsed low mid-ACTIVE (after 0x22) -> outputs 0 asynchronously and busy=0. The subsequent full frame produces correct windows.

Source files
------------

// File: rtl/window_buffer.sv
// Raster-order pixel stream to 3x3 neighbourhood generator feeding the Sobel stage.
// Two line-length shift registers supply the two rows above the incoming pixel.
module window_buffer #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int CNT_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic                 pixel_valid,
  input  logic [7:0]           pixel_in,
  output logic [2:0][2:0][7:0] comp_matrix,
  output logic                 sobel_en,
  output logic                 frame_done,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  // Handshake: a pixel is taken in every cycle with pixel_valid=1 and clear=0
  // (no backpressure); sobel_en qualifies comp_matrix for exactly one cycle.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [CNT_BITS-1:0] COL_LAST = CNT_BITS'(IMG_WIDTH - 1);
  localparam logic [CNT_BITS-1:0] ROW_LAST = CNT_BITS'(IMG_HEIGHT - 1);
  localparam logic [CNT_BITS-1:0] ONE      = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] TWO      = CNT_BITS'(2);

  state_t                  state_q;
  logic                    busy_q;
  logic                    sobel_en_q;
  logic                    frame_done_q;
  logic [CNT_BITS-1:0]     col_q, col_d;
  logic [CNT_BITS-1:0]     row_q, row_d;
  logic [IMG_WIDTH-1:0][7:0] line0_q;
  logic [IMG_WIDTH-1:0][7:0] line1_q;
  logic [2:0][2:0][7:0]    win_q;

  logic accept;
  logic col_last;
  logic row_last;
  logic interior;

  assign accept   = pixel_valid & ~clear;
  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);
  assign interior = (row_q >= TWO) && (col_q >= TWO);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (pixel_valid) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col_q        <= '0;
      row_q        <= '0;
      sobel_en_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      sobel_en_q   <= accept && interior;
      frame_done_q <= accept && row_last && col_last;
    end
  end

  // Window shifts on every accept, including row starts, so that column 2 of
  // each row already has the correct two left columns loaded.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      win_q   <= '0;
      line0_q <= '0;
      line1_q <= '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[2][2] <= pixel_in;
      win_q[1][2] <= line1_q[IMG_WIDTH-1];
      win_q[0][2] <= line0_q[IMG_WIDTH-1];
      line1_q     <= {line1_q[IMG_WIDTH-2:0], pixel_in};
      line0_q     <= {line0_q[IMG_WIDTH-2:0], line1_q[IMG_WIDTH-1]};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else if (pixel_valid) begin
      case (state_q)
        IDLE: begin
          state_q <= FILL;
          busy_q  <= 1'b1;
        end
        FILL: begin
          if ((row_q == ONE) && col_last) begin
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (row_last && col_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign comp_matrix = win_q;
  assign sobel_en    = sobel_en_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_window_buffer.sv
// Bench for window_buffer on a 4x4 frame: directed frames plus randomized pixels
// and gaps, all checked against a position-indexed image model.
module tb_window_buffer;
  localparam int W = 4;
  localparam int H = 4;

  logic                 clk = 1'b0;
  logic                 n_rst = 1'b1;
  logic                 clear = 1'b0;
  logic                 pixel_valid = 1'b0;
  logic [7:0]           pixel_in = '0;
  logic [2:0][2:0][7:0] comp_matrix;
  logic                 sobel_en;
  logic                 frame_done;
  logic                 busy;
  logic [1:0]           state_dbg;

  always #5 clk = ~clk;

  window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_BITS(8)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (clear),
    .pixel_valid (pixel_valid),
    .pixel_in    (pixel_in),
    .comp_matrix (comp_matrix),
    .sobel_en    (sobel_en),
    .frame_done  (frame_done),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt;
  int done_cnt;

  // Reference model: the current frame as a flat image indexed by raster position.
  logic [7:0]  img [W*H];
  int          pos = 0;
  bit          in_frame = 0;
  bit          win_known = 0;
  logic [71:0] exp_q[$];
  logic [71:0] last_win;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [71:0] window_at(input int row, input int col);
    logic [2:0][2:0][7:0] w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[r][c] = img[(row - 2 + r) * W + (col - 2 + c)];
    return w;
  endfunction

  task automatic step(input bit v, input bit c, input logic [7:0] p);
    bit e_en;
    bit e_done;
    int row;
    int col;
    pixel_valid = v;
    clear       = c;
    pixel_in    = p;
    e_en   = 0;
    e_done = 0;
    if (c) begin
      pos = 0;
      in_frame = 0;
      win_known = 0;
    end else if (v) begin
      row = pos / W;
      col = pos % W;
      img[pos] = p;
      in_frame = 1;
      if (row >= 2 && col >= 2) begin
        e_en = 1;
        exp_q.push_back(window_at(row, col));
        win_known = 1;
      end else begin
        win_known = 0;
      end
      if (pos == W * H - 1) begin
        e_done = 1;
        pos = 0;
        in_frame = 0;
      end else begin
        pos++;
      end
    end
    @(posedge clk);
    #1;
    check("sobel_en", sobel_en, e_en);
    check("frame_done", frame_done, e_done);
    check("busy", busy, in_frame);
    if (sobel_en) pulse_cnt++;
    if (frame_done) done_cnt++;
    if (e_en) begin
      last_win = exp_q.pop_front();
      check("window", comp_matrix, last_win);
    end else if (win_known) begin
      check("hold", comp_matrix, last_win);
    end
    pixel_valid = 1'b0;
    clear       = 1'b0;
  endtask

  function automatic logic [7:0] raster_pix(input logic [7:0] base, input int i);
    return base + 8'(16 * (i / W) + (i % W));
  endfunction

  // gaps: 0 none, 1 two idle cycles after each pixel, 2 random 0..2 idle cycles
  task automatic frame(input bit rnd, input logic [7:0] base, input int gaps);
    logic [7:0] p;
    for (int i = 0; i < W * H; i++) begin
      p = rnd ? 8'($urandom) : raster_pix(base, i);
      step(1'b1, 1'b0, p);
      if (gaps == 1) begin
        step(1'b0, 1'b0, 8'($urandom));
        step(1'b0, 1'b0, 8'($urandom));
      end else if (gaps == 2) begin
        repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 8'($urandom));
      end
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #2;
    check("rst_sobel_en", sobel_en, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_matrix", comp_matrix, 72'h0);
    check("rst_state", state_dbg, 2'd0);
    pos = 0;
    in_frame = 0;
    win_known = 0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  logic [2:0][2:0][7:0] k;

  initial begin
    #1;
    do_reset();

    // Full frame, valid held high, with directed window constants
    pulse_cnt = 0; done_cnt = 0;
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, 1'b0, raster_pix(8'h00, i));
      if (i == 10) begin
        k = {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};
        check("first_win", comp_matrix, k);
      end
      if (i == 14) begin
        k = {8'h32, 8'h31, 8'h30, 8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10};
        check("wrap_win", comp_matrix, k);
      end
    end
    check("pulses_plain", pulse_cnt, 4);
    check("done_plain", done_cnt, 1);

    // Toggled valid 1,0,0,1...
    pulse_cnt = 0; done_cnt = 0;
    frame(1'b0, 8'h00, 1);
    check("pulses_gap", pulse_cnt, 4);
    check("done_gap", done_cnt, 1);

    // Back-to-back frames, second offset by 0x80
    pulse_cnt = 0; done_cnt = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < W * H; i++) begin
        step(1'b1, 1'b0, raster_pix(f == 1 ? 8'h80 : 8'h00, i));
        if (f == 1 && i == 10) begin
          k = {8'hA2, 8'hA1, 8'hA0, 8'h92, 8'h91, 8'h90, 8'h82, 8'h81, 8'h80};
          check("fifth_win", comp_matrix, k);
        end
      end
    end
    check("pulses_b2b", pulse_cnt, 8);
    check("done_b2b", done_cnt, 2);

    // Clear after 0x21 with a pixel presented alongside, then a fresh frame
    pulse_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, raster_pix(8'h00, i));
    step(1'b1, 1'b1, 8'h22);
    check("clear_state", state_dbg, 2'd0);
    frame(1'b0, 8'h40, 0);
    check("pulses_clear", pulse_cnt, 4);
    check("done_clear", done_cnt, 1);

    // Reset mid-ACTIVE after 0x22, then a full frame
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, raster_pix(8'h00, i));
    do_reset();
    pulse_cnt = 0; done_cnt = 0;
    frame(1'b0, 8'h10, 0);
    check("pulses_rst", pulse_cnt, 4);
    check("done_rst", done_cnt, 1);

    // Randomized pixels and gaps, with an occasional mid-frame clear
    pulse_cnt = 0; done_cnt = 0;
    for (int f = 0; f < 8; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < $urandom_range(1, W * H - 1); i++) step(1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b1, 8'($urandom));
      end
      frame(1'b1, 8'h00, 2);
    end
    check("done_rand", done_cnt, 8);
    check("queue_empty", 72'(exp_q.size()), 72'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
